meta_write_arbiter: RTL and testbench
=====================================

META_WRITE_ARBITER -- requirements
Module: meta_write_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, number of requester channels (N >= 2).
REQ-002 The block SHALL have parameter W, default 36, payload width per channel (idx 6 + way_en 8 + coh_state 2 + tag 20).
REQ-003 The block SHALL have parameter RR, default 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-004 The block SHALL have local parameter IW = clog2(N).
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  N  per-channel request valid.
REQ-008 in_bits  input  N*W  per-channel payload; channel i occupies bits [i*W +: W].
REQ-009 in_lock  input  N  per-channel hold-grant flag, sampled with the accepted beat.
REQ-010 in_ready  output  N  per-channel accept; at most one bit high per cycle.
REQ-011 out_valid  output  1  registered output valid.
REQ-012 out_bits  output  W  registered payload of the accepted beat.
REQ-013 out_chosen  output  IW  index of the channel that supplied out_bits.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 The block SHALL hold one output register; accept = !out_valid | out_ready (full throughput, one beat per cycle).
REQ-016 The block SHALL hold state ptr (IW bits), lock_active (1 bit) and lock_owner (IW bits).
REQ-017 When lock_active=1, the grant SHALL go only to lock_owner, and only if in_valid[lock_owner]=1; otherwise no channel is granted (stall, others blocked).
REQ-018 When lock_active=0 and RR=1, the grant SHALL go to the first valid channel scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-019 When lock_active=0 and RR=0, the grant SHALL go to the lowest-index valid channel; ptr is ignored.
REQ-020 in_ready[i] SHALL equal accept & granted(i); with no valid channel, in_ready SHALL be all zero.
REQ-021 A transfer from channel i occurs when in_valid[i] & in_ready[i]; next cycle out_valid=1, out_bits=in_bits[i], out_chosen=i (latency 1 cycle).
REQ-022 On a transfer from i with RR=1, ptr SHALL become i+1, wrapping N-1 -> 0; with no transfer ptr SHALL hold.
REQ-023 On a transfer from i, lock_active SHALL become in_lock[i] and lock_owner SHALL become i; with no transfer both SHALL hold.
REQ-024 When out_ready=1 and no transfer occurs, out_valid SHALL clear next cycle; out_bits and out_chosen SHALL hold their last values.
REQ-025 When out_valid=1 and out_ready=0, out_valid, out_bits and out_chosen SHALL hold, and in_ready SHALL be all zero.
REQ-026 Simultaneous out_ready=1 and a new transfer SHALL replace the register contents with no bubble.
REQ-027 The block SHALL NOT require in_valid to stay asserted; a withdrawn request simply loses arbitration.
REQ-028 Locking SHALL be honoured identically in RR=0 and RR=1 modes.

Reset
REQ-029 On reset low, the block SHALL clear immediately: out_valid=0, out_bits=0, out_chosen=0, ptr=0, lock_active=0, lock_owner=0.
REQ-030 While reset is low, in_ready SHALL be all zero.
REQ-031 A beat held in the output register when reset asserts SHALL be discarded.
REQ-032 The first grant after reset deasserts SHALL follow REQ-018/019 with ptr=0.

Verification
REQ-033 RR=1, N=8, out_ready=1, all in_valid=1, in_lock=0 for 10 cycles -> out_chosen sequence 0,1,...,7,0,1, one beat per cycle.
REQ-034 RR=0, in_valid=0x0C, out_ready=1 -> in_ready=0x04 every cycle; out_chosen=2 repeatedly; channel 3 never granted.
REQ-035 RR=1, ch5 beat with in_lock[5]=1, then in_valid=0x21 with in_lock[5]=0 -> second beat also from ch5; next grant goes to ch0 (ptr=6, wraps).
REQ-036 Lock held by ch2 and in_valid[2] drops with in_valid=0x01 for 3 cycles -> in_ready=0 and out_valid falls; ch2 reasserts -> ch2 granted.
REQ-037 out_ready=0 for 4 cycles with out_valid=1 and payload 0xABCDE12 from ch1 -> out_bits stable and in_ready=0; out_ready=1 -> next beat loads in the same cycle.
REQ-038 Reset pulsed low mid-stream with out_valid=1 and lock_active=1 -> out_valid=0 without a clock edge; after release, all valid -> first out_chosen=0.

Source files
------------

// File: rtl/meta_write_arbiter.sv
// meta_write_arbiter: N-to-1 metadata write arbiter with round-robin or fixed priority,
// per-channel grant locking and a single registered output stage.
module meta_write_arbiter #(
    parameter int N  = 8,
    parameter int W  = 36,
    parameter int RR = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N-1:0]          in_valid_i,
    input  logic [N*W-1:0]        in_bits_i,
    input  logic [N-1:0]          in_lock_i,
    output logic [N-1:0]          in_ready_o,
    output logic                  out_valid_o,
    output logic [W-1:0]          out_bits_o,
    output logic [$clog2(N)-1:0]  out_chosen_o,
    input  logic                  out_ready_i
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q, ptr_d, lock_owner_q, lock_owner_d, out_chosen_q, out_chosen_d;
    logic          lock_active_q, lock_active_d, out_valid_q, out_valid_d;
    logic [W-1:0]  out_bits_q, out_bits_d;
    logic [IW-1:0] sel, idx;
    logic          found, accept, xfer;

    assign accept = !out_valid_q || out_ready_i;
    assign xfer   = found && accept && rst_ni;

    // A held lock pins the grant to its owner, even if that stalls everyone else.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        if (lock_active_q) begin
            found = in_valid_i[lock_owner_q];
            sel   = lock_owner_q;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (RR != 0) ? IW'((int'(ptr_q) + k) % N) : IW'(k);
                if (!found && in_valid_i[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
        end
    end

    always_comb begin
        in_ready_o = '0;
        if (xfer) in_ready_o[sel] = 1'b1;
    end

    always_comb begin
        out_valid_d   = xfer ? 1'b1 : (out_ready_i ? 1'b0 : out_valid_q);
        out_bits_d    = xfer ? in_bits_i[sel*W +: W] : out_bits_q;
        out_chosen_d  = xfer ? sel : out_chosen_q;
        lock_active_d = xfer ? in_lock_i[sel] : lock_active_q;
        lock_owner_d  = xfer ? sel : lock_owner_q;
        ptr_d         = (xfer && RR != 0) ? ((sel == IW'(N - 1)) ? '0 : sel + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q   <= 1'b0;
            out_bits_q    <= '0;
            out_chosen_q  <= '0;
            ptr_q         <= '0;
            lock_active_q <= 1'b0;
            lock_owner_q  <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_bits_q    <= out_bits_d;
            out_chosen_q  <= out_chosen_d;
            ptr_q         <= ptr_d;
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_bits_o   = out_bits_q;
    assign out_chosen_o = out_chosen_q;
endmodule

// File: tb/tb_meta_write_arbiter.sv
// tb_meta_write_arbiter: directed checks of a round-robin and a fixed-priority instance
// driven from the same stimulus.
module tb_meta_write_arbiter;
    localparam int N = 8;
    localparam int W = 36;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid, in_lock;
    logic [N*W-1:0] in_bits;
    logic           out_ready;
    logic [N-1:0]   rdy_r, rdy_f;
    logic           ov_r, ov_f;
    logic [W-1:0]   ob_r, ob_f;
    logic [2:0]     oc_r, oc_f;
    int             errors = 0;
    int             checks = 0;

    always #5 clk = ~clk;

    meta_write_arbiter #(.N(N), .W(W), .RR(1)) u_rr (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_bits_i(in_bits),
        .in_lock_i(in_lock), .in_ready_o(rdy_r), .out_valid_o(ov_r), .out_bits_o(ob_r),
        .out_chosen_o(oc_r), .out_ready_i(out_ready)
    );

    meta_write_arbiter #(.N(N), .W(W), .RR(0)) u_fp (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_bits_i(in_bits),
        .in_lock_i(in_lock), .in_ready_o(rdy_f), .out_valid_o(ov_f), .out_bits_o(ob_f),
        .out_chosen_o(oc_f), .out_ready_i(out_ready)
    );

    function automatic logic [W-1:0] pay(int i);
        return {4'(i), 32'hC0DE0000 + 32'(i)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = '0;
        in_lock = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_bits[i*W +: W] = pay(i);
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = '1;
        in_lock = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_bits[i*W +: W] = pay(i);
        #3;
        checks++; if (rdy_r !== 8'h00) begin errors++; $display("FAIL reset_rdy_rr: got %h want 00", rdy_r); end
        checks++; if (rdy_f !== 8'h00) begin errors++; $display("FAIL reset_rdy_fp: got %h want 00", rdy_f); end
        cyc();
        checks++; if (ov_r !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ov_r); end
        checks++; if (ob_r !== 36'h0) begin errors++; $display("FAIL reset_bits: got %h want 0", ob_r); end
        checks++; if (oc_r !== 3'd0) begin errors++; $display("FAIL reset_chosen: got %0d want 0", oc_r); end
        checks++; if (rdy_r !== 8'h00) begin errors++; $display("FAIL reset_rdy_held: got %h want 00", rdy_r); end
        rst_n = 1'b1;
    endtask

    task automatic test_rr_sweep();
        logic [7:0] exp;
        apply_reset();
        in_valid = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            exp = 8'h01 << (c % 8);
            #1;
            checks++; if (rdy_r !== exp) begin errors++; $display("FAIL rr_ready[%0d]: got %h want %h", c, rdy_r, exp); end
            checks++; if (rdy_f !== 8'h01) begin errors++; $display("FAIL fp_all_ready[%0d]: got %h want 01", c, rdy_f); end
            cyc();
            checks++; if (ov_r !== 1'b1 || oc_r !== 3'(c % 8)) begin errors++; $display("FAIL rr_chosen[%0d]: got v=%b %0d want v=1 %0d", c, ov_r, oc_r, c % 8); end
            checks++; if (ob_r !== pay(c % 8)) begin errors++; $display("FAIL rr_bits[%0d]: got %h want %h", c, ob_r, pay(c % 8)); end
        end
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        in_valid = 8'h0C;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (rdy_f !== 8'h04) begin errors++; $display("FAIL fp_ready[%0d]: got %h want 04", c, rdy_f); end
            cyc();
            checks++; if (ov_f !== 1'b1 || oc_f !== 3'd2) begin errors++; $display("FAIL fp_chosen[%0d]: got v=%b %0d want v=1 2", c, ov_f, oc_f); end
        end
    endtask

    task automatic test_lock_wrap();
        apply_reset();
        in_valid = 8'h20;
        in_lock = 8'h20;
        cyc();
        checks++; if (oc_r !== 3'd5 || oc_f !== 3'd5) begin errors++; $display("FAIL lock_first: got rr=%0d fp=%0d want 5", oc_r, oc_f); end
        in_valid = 8'h21;
        in_lock = 8'h00;
        #1;
        checks++; if (rdy_r !== 8'h20) begin errors++; $display("FAIL lock_rdy_rr: got %h want 20", rdy_r); end
        checks++; if (rdy_f !== 8'h20) begin errors++; $display("FAIL lock_rdy_fp: got %h want 20", rdy_f); end
        cyc();
        checks++; if (oc_r !== 3'd5 || oc_f !== 3'd5) begin errors++; $display("FAIL lock_second: got rr=%0d fp=%0d want 5", oc_r, oc_f); end
        #1;
        checks++; if (rdy_r !== 8'h01) begin errors++; $display("FAIL lock_wrap_rdy: got %h want 01", rdy_r); end
        cyc();
        checks++; if (oc_r !== 3'd0 || oc_f !== 3'd0) begin errors++; $display("FAIL lock_release: got rr=%0d fp=%0d want 0", oc_r, oc_f); end
    endtask

    task automatic test_lock_stall();
        apply_reset();
        in_valid = 8'h04;
        in_lock = 8'h04;
        cyc();
        checks++; if (oc_r !== 3'd2 || ov_r !== 1'b1) begin errors++; $display("FAIL stall_grant: got v=%b %0d want v=1 2", ov_r, oc_r); end
        in_valid = 8'h01;
        in_lock = 8'h00;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rdy_r !== 8'h00 || rdy_f !== 8'h00) begin errors++; $display("FAIL stall_rdy[%0d]: got rr=%h fp=%h want 00", c, rdy_r, rdy_f); end
            cyc();
            checks++; if (ov_r !== 1'b0 || ov_f !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got rr=%b fp=%b want 0", c, ov_r, ov_f); end
        end
        checks++; if (oc_r !== 3'd2 || ob_r !== pay(2)) begin errors++; $display("FAIL stall_hold: got %0d %h want 2 %h", oc_r, ob_r, pay(2)); end
        in_valid = 8'h04;
        #1;
        checks++; if (rdy_r !== 8'h04) begin errors++; $display("FAIL stall_resume_rdy: got %h want 04", rdy_r); end
        cyc();
        checks++; if (ov_r !== 1'b1 || oc_r !== 3'd2) begin errors++; $display("FAIL stall_resume: got v=%b %0d want v=1 2", ov_r, oc_r); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        in_bits[1*W +: W] = 36'h0ABCDE12;
        in_valid = 8'h02;
        cyc();
        checks++; if (ov_r !== 1'b1 || ob_r !== 36'h0ABCDE12) begin errors++; $display("FAIL bp_load: got v=%b %h want v=1 0abcde12", ov_r, ob_r); end
        out_ready = 1'b0;
        in_bits[1*W +: W] = 36'h123456789;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (rdy_r !== 8'h00) begin errors++; $display("FAIL bp_rdy[%0d]: got %h want 00", c, rdy_r); end
            cyc();
            checks++; if (ov_r !== 1'b1 || ob_r !== 36'h0ABCDE12 || oc_r !== 3'd1) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h %0d want v=1 0abcde12 1", c, ov_r, ob_r, oc_r); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (rdy_r !== 8'h02) begin errors++; $display("FAIL bp_release_rdy: got %h want 02", rdy_r); end
        cyc();
        checks++; if (ov_r !== 1'b1 || ob_r !== 36'h123456789) begin errors++; $display("FAIL bp_replace: got v=%b %h want v=1 123456789", ov_r, ob_r); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        in_valid = 8'h08;
        in_lock = 8'h08;
        cyc();
        checks++; if (ov_r !== 1'b1 || oc_r !== 3'd3) begin errors++; $display("FAIL mid_setup: got v=%b %0d want v=1 3", ov_r, oc_r); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ov_r !== 1'b0 || ov_f !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got rr=%b fp=%b want 0", ov_r, ov_f); end
        checks++; if (ob_r !== 36'h0 || oc_r !== 3'd0) begin errors++; $display("FAIL mid_async_clear: got %h %0d want 0 0", ob_r, oc_r); end
        checks++; if (rdy_r !== 8'h00) begin errors++; $display("FAIL mid_rdy_in_reset: got %h want 00", rdy_r); end
        cyc();
        rst_n = 1'b1;
        in_valid = 8'hFF;
        in_lock = 8'h00;
        #1;
        checks++; if (rdy_r !== 8'h01) begin errors++; $display("FAIL mid_after_rdy: got %h want 01", rdy_r); end
        cyc();
        checks++; if (ov_r !== 1'b1 || oc_r !== 3'd0) begin errors++; $display("FAIL mid_after_chosen: got v=%b %0d want v=1 0", ov_r, oc_r); end
    endtask

    initial begin
        test_reset();
        test_rr_sweep();
        test_fixed_priority();
        test_lock_wrap();
        test_lock_stall();
        test_backpressure();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
